// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud divider, rx synchroniser, between-frame config sequencer and FWFT receive FIFO
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16,
   parameter int RESET_DIV  = 53
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic                              cfg_wr,
   input  logic                              cfg_enable,
   input  logic [DIV_W-1:0]                  cfg_div,
   input  logic [1:0]                        cfg_frame_type,
   input  logic [1:0]                        cfg_parity_type,
   input  logic                              cfg_stop_type,
   input  logic                              ovr_clr,
   input  logic                              rx_pin,
   output logic                              rx_sync,
   output logic                              rx_negedge_det,
   output logic                              active,
   output logic                              recv_clk_en,
   output logic [1:0]                        frame_type,
   output logic [1:0]                        parity_type,
   output logic                              stop_type,
   input  logic                              rcv_recv,
   input  logic                              rcv_error,
   input  logic [7:0]                        rcv_data,
   input  logic                              rcv_busy,
   output logic                              rd_valid,
   input  logic                              rd_ready,
   output logic [7:0]                        rd_data,
   output logic                              rd_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              overrun,
   output logic                              cfg_pending
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   typedef enum logic [1:0] {OFF, ON, PEND} state_t;
   state_t state_q, state_d;
   logic [2:0] sync_q, sync_d;
   logic sh_en_q, sh_en_d, sh_stop_q, sh_stop_d, stop_q, stop_d;
   logic [DIV_W-1:0] sh_div_q, sh_div_d, div_q, div_d, cnt_q, cnt_d;
   logic [1:0] sh_frame_q, sh_frame_d, sh_par_q, sh_par_d, frame_q, frame_d, par_q, par_d;
   logic [8:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic ovr_q, ovr_d;
   logic full, do_push, do_pop, drop;
   // sync_q = {history, stage2, stage1}
   assign sync_d         = {sync_q[1], sync_q[0], rx_pin};
   assign rx_sync        = sync_q[1];
   assign rx_negedge_det = sync_q[2] & ~sync_q[1];
   assign active         = state_q == ON;
   assign cfg_pending    = state_q == PEND;
   assign recv_clk_en    = (state_q != OFF) && (cnt_q == div_q);
   assign frame_type     = frame_q;
   assign parity_type    = par_q;
   assign stop_type      = stop_q;
   always_comb begin
      state_d    = state_q;
      sh_en_d    = sh_en_q;
      sh_div_d   = sh_div_q;
      sh_frame_d = sh_frame_q;
      sh_par_d   = sh_par_q;
      sh_stop_d  = sh_stop_q;
      div_d      = div_q;
      frame_d    = frame_q;
      par_d      = par_q;
      stop_d     = stop_q;
      cnt_d      = (state_q == OFF || recv_clk_en) ? '0 : cnt_q + DIV_W'(1);
      if (cfg_wr) begin
         sh_en_d    = cfg_enable;
         sh_div_d   = cfg_div;
         sh_frame_d = cfg_frame_type;
         sh_par_d   = cfg_parity_type;
         sh_stop_d  = cfg_stop_type;
         state_d    = PEND;
      end else if (state_q == PEND && !rcv_busy) begin
         div_d   = sh_div_q;
         frame_d = sh_frame_q;
         par_d   = sh_par_q;
         stop_d  = sh_stop_q;
         cnt_d   = '0;
         state_d = sh_en_q ? ON : OFF;
      end
   end
   assign full       = lvl_q == LW'(FIFO_DEPTH);
   assign rd_valid   = lvl_q != '0;
   assign do_pop     = rd_valid & rd_ready;
   assign do_push    = rcv_recv & (~full | do_pop);
   assign drop       = rcv_recv & full & ~do_pop;
   assign rd_data    = mem_q[rp_q][7:0];
   assign rd_err     = mem_q[rp_q][8];
   assign fifo_level = lvl_q;
   assign overrun    = ovr_q;
   always_comb begin
      wp_d  = do_push ? wp_q + AW'(1) : wp_q;
      rp_d  = do_pop ? rp_q + AW'(1) : rp_q;
      lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
      ovr_d = drop ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
   end
   always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= {rcv_error, rcv_data};
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= OFF;
         sync_q     <= 3'b111;
         sh_en_q    <= 1'b0;
         sh_div_q   <= DIV_W'(RESET_DIV);
         sh_frame_q <= 2'b11;
         sh_par_q   <= 2'b00;
         sh_stop_q  <= 1'b0;
         div_q      <= DIV_W'(RESET_DIV);
         frame_q    <= 2'b11;
         par_q      <= 2'b00;
         stop_q     <= 1'b0;
         cnt_q      <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         lvl_q      <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         sh_en_q    <= sh_en_d;
         sh_div_q   <= sh_div_d;
         sh_frame_q <= sh_frame_d;
         sh_par_q   <= sh_par_d;
         sh_stop_q  <= sh_stop_d;
         div_q      <= div_d;
         frame_q    <= frame_d;
         par_q      <= par_d;
         stop_q     <= stop_d;
         cnt_q      <= cnt_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         lvl_q      <= lvl_d;
         ovr_q      <= ovr_d;
      end
   end
endmodule
